uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, defaults and helpers
// for the UART transmit arbiter and its baud generator.
package uart_pkg;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_BAUD_DIV = 16;
   localparam int OWNER_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_LAUNCH    = 2'b01,
      ST_WAIT_BUSY = 2'b10,
      ST_WAIT_DONE = 2'b11
   } arb_state_e;

   // Round-robin start point after serving idx among n requesters.
   function automatic logic [OWNER_W-1:0] rr_next(
      input logic [OWNER_W-1:0] idx,
      input int                 n
   );
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + OWNER_W'(1);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle
// tick every BAUD_DIV clocks (on count BAUD_DIV-1).
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Wrap at BAUD_DIV-1, otherwise increment.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART sender
// among NUM_REQ byte requesters, plus the sender baud enable.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic                 tx_wr_en,
   output logic [7:0]           tx_data,
   output logic                 tx_enb,
   input  logic                 tx_busy,
   output logic                 arb_busy,
   output logic [2:0]           owner
);

   arb_state_e         state_q;
   arb_state_e         state_d;
   logic [OWNER_W-1:0] owner_q;
   logic [OWNER_W-1:0] owner_d;
   logic [OWNER_W-1:0] rr_ptr_q;
   logic [OWNER_W-1:0] rr_ptr_d;
   logic [7:0]         tx_data_q;
   logic [7:0]         tx_data_d;

   logic               win_found;
   logic [OWNER_W-1:0] win_idx;
   logic [7:0]         win_byte;

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tx_enb)
   );

   // First pending requester scanning upward from rr_ptr, wrapping.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      win_byte  = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = OWNER_W'(idx);
            win_byte  = req_data[8*idx +: 8];
         end
      end
   end

   // Next-state, owner, latched byte and pointer update.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      tx_data_d = tx_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (win_found && !tx_busy) begin
               owner_d   = win_idx;
               tx_data_d = win_byte;
               state_d   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               rr_ptr_d = rr_next(owner_q, NUM_REQ);
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Per-requester grant and completion pulses decoded from state.
   always_comb begin
      gnt  = '0;
      done = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i]  = (state_q == ST_LAUNCH)
                 && (int'(owner_q) == i);
         done[i] = (state_q == ST_WAIT_DONE) && !tx_busy
                 && (int'(owner_q) == i);
      end
   end

   // State, owner, pointer and byte registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_wr_en = (state_q == ST_LAUNCH);
   assign tx_data  = tx_data_q;
   assign arb_busy = (state_q != ST_IDLE);
   assign owner    = owner_q;

endmodule
